// File: rtl/bram_port_arbiter_if.sv
// Requester-side BRAM access channel: one request/ack handshake per transaction.
// The requester drives the master modport and the arbiter owns the slave modport.
`timescale 1ns/1ps
interface bram_port_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        stall;

    modport master (output req, we, addr, wdata, input rdata, ack, stall);
    modport slave  (input req, we, addr, wdata, output rdata, ack, stall);
endinterface

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port between the CPU and the boot loader, covering read latency
// with a counter and holding the CPU off the port until the loader reports boot done.
`timescale 1ns/1ps
module bram_port_arbiter #(
    parameter int BRAM_SIZE    = 18,
    parameter int READ_LATENCY = 2,
    parameter bit BOOT_LOCK    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    bram_port_arbiter_if.slave   cpu,
    bram_port_arbiter_if.slave   ldr,
    input  logic                 i_boot_done,
    output logic                 o_run,
    output logic [BRAM_SIZE-1:0] o_bram_addra,
    output logic [31:0]          o_bram_dina,
    output logic                 o_bram_wea,
    input  logic [31:0]          i_bram_douta
);

    typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, RD = 2'd2} state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic                 r_grantB;
    logic                 r_lastGrantB;
    logic                 r_booting;
    logic                 r_ackHold;
    logic [3:0]           r_cnt;
    logic [BRAM_SIZE-1:0] r_bramAddr;
    logic [31:0]          r_bramDin;
    logic                 r_bramWe;
    logic                 r_cAck;
    logic                 r_bAck;
    logic [31:0]          r_cRdata;
    logic [31:0]          r_bRdata;

    logic                 w_cReq;
    logic                 w_bReq;
    logic                 w_accept;
    logic                 w_grantB;
    logic                 w_capture;
    logic                 w_we;
    logic [31:0]          w_addr;
    logic [31:0]          w_wdata;
    logic                 w_unused;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nextState;
    end

    // r_ackHold keeps the IDLE cycle that carries a read ack from accepting a new request
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_grantB    = r_grantB;
        w_capture   = 1'b0;
        w_cReq      = cpu.req & ~r_booting;
        w_bReq      = ldr.req;
        case (r_state)
            IDLE: begin
                if (!r_ackHold && (w_cReq || w_bReq)) begin
                    w_accept    = 1'b1;
                    w_grantB    = (w_cReq && w_bReq) ? ~r_lastGrantB : w_bReq;
                    w_nextState = (w_grantB ? ldr.we : cpu.we) ? WR : RD;
                end
            end
            WR: w_nextState = IDLE;
            RD: begin
                if (r_cnt == 4'(READ_LATENCY)) begin
                    w_capture   = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
        w_we    = w_grantB ? ldr.we    : cpu.we;
        w_addr  = w_grantB ? ldr.addr  : cpu.addr;
        w_wdata = w_grantB ? ldr.wdata : cpu.wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grantB     <= 1'b0;
            r_lastGrantB <= 1'b1;
            r_booting    <= BOOT_LOCK;
            r_ackHold    <= 1'b0;
            r_cnt        <= '0;
            r_bramAddr   <= '0;
            r_bramDin    <= '0;
            r_bramWe     <= 1'b0;
            r_cAck       <= 1'b0;
            r_bAck       <= 1'b0;
            r_cRdata     <= '0;
            r_bRdata     <= '0;
        end else begin
            r_cAck    <= 1'b0;
            r_bAck    <= 1'b0;
            r_bramWe  <= 1'b0;
            r_ackHold <= w_capture;
            if (i_boot_done) r_booting <= 1'b0;
            if (w_accept) begin
                r_grantB     <= w_grantB;
                r_lastGrantB <= w_grantB;
                r_bramAddr   <= w_addr[BRAM_SIZE+1:2];
                r_bramDin    <= w_wdata;
                r_cnt        <= '0;
                if (w_we) begin
                    r_bramWe <= 1'b1;
                    if (w_grantB) r_bAck <= 1'b1;
                    else          r_cAck <= 1'b1;
                end
            end
            if (r_state == RD && !w_capture) r_cnt <= r_cnt + 4'd1;
            if (w_capture) begin
                if (r_grantB) begin
                    r_bRdata <= i_bram_douta;
                    r_bAck   <= 1'b1;
                end else begin
                    r_cRdata <= i_bram_douta;
                    r_cAck   <= 1'b1;
                end
            end
        end
    end

    assign cpu.ack      = r_cAck;
    assign cpu.rdata    = r_cRdata;
    assign cpu.stall    = cpu.req & ~r_cAck;
    assign ldr.ack      = r_bAck;
    assign ldr.rdata    = r_bRdata;
    assign ldr.stall    = ldr.req & ~r_bAck;
    assign o_run        = ~r_booting;
    assign o_bram_addra = r_bramAddr;
    assign o_bram_dina  = r_bramDin;
    assign o_bram_wea   = r_bramWe;
    assign w_unused     = ^{w_addr[31:BRAM_SIZE+2], w_addr[1:0]};

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter: requesters push expected responses,
// a negedge monitor pops them on every ack and on every BRAM write pulse.
`timescale 1ns/1ps
module tb_bram_port_arbiter;
    localparam int BS = 18;
    localparam int RL = 2;

    typedef struct {logic we; logic [31:0] data;} exp_t;
    typedef struct {logic who; logic [31:0] idx; logic [31:0] data;} wr_t;

    logic          clk;
    logic          rst;
    logic          bootDone;
    logic          run;
    logic [BS-1:0] bramAddra;
    logic [31:0]   bramDina;
    logic          bramWea;
    logic [31:0]   bramDouta;

    bram_port_arbiter_if cIf ();
    bram_port_arbiter_if bIf ();

    bram_port_arbiter #(.BRAM_SIZE(BS), .READ_LATENCY(RL), .BOOT_LOCK(1'b1)) dut (
        .clk(clk), .rst(rst), .cpu(cIf), .ldr(bIf),
        .i_boot_done(bootDone), .o_run(run),
        .o_bram_addra(bramAddra), .o_bram_dina(bramDina),
        .o_bram_wea(bramWea), .i_bram_douta(bramDouta)
    );

    int checks = 0;
    int passes = 0;
    int cAckCount = 0;
    int bAckCount = 0;
    exp_t cExp[$];
    exp_t bExp[$];
    wr_t  wrQ[$];
    int   ackLog[$];
    logic [31:0] refMem [int];

    // BRAM with a READ_LATENCY-deep output pipeline
    logic [31:0] bramMem [0:(1<<BS)-1];
    logic [31:0] rdPipe [RL];

    initial begin
        for (int i = 0; i < (1<<BS); i++) bramMem[i] = 32'h0;
        for (int i = 0; i < RL; i++) rdPipe[i] = 32'h0;
    end

    always @(posedge clk) begin
        if (bramWea) bramMem[bramAddra] <= bramDina;
        rdPipe[0] <= bramMem[bramAddra];
        for (int k = 1; k < RL; k++) rdPipe[k] <= rdPipe[k-1];
    end
    assign bramDouta = rdPipe[RL-1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    endtask

    function automatic logic [31:0] wordIdx(input logic [31:0] addr);
        return (addr >> 2) % (32'd1 << BS);
    endfunction

    function automatic logic [31:0] refRead(input logic [31:0] idx);
        return refMem.exists(int'(idx)) ? refMem[int'(idx)] : 32'h0;
    endfunction

    function automatic logic [31:0] randAddr(input int base);
        logic [31:0] hi;
        hi = $urandom & 32'hFFF;
        return (hi << 20) | (32'(base + $urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    // Issue one transaction: record the expected outcome, drive it, wait for its ack
    task automatic applyStimulus(input bit who, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input bit drop, input bit chkLat);
        exp_t e;
        wr_t  w;
        int   n;
        logic seen;
        e.we   = we;
        e.data = we ? 32'h0 : refRead(wordIdx(addr));
        if (we) begin
            refMem[int'(wordIdx(addr))] = wdata;
            w.who = who; w.idx = wordIdx(addr); w.data = wdata;
            wrQ.push_back(w);
        end
        if (who) begin
            bExp.push_back(e);
            bIf.req = 1'b1; bIf.we = we; bIf.addr = addr; bIf.wdata = wdata;
        end else begin
            cExp.push_back(e);
            cIf.req = 1'b1; cIf.we = we; cIf.addr = addr; cIf.wdata = wdata;
        end
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            seen = who ? bIf.ack : cIf.ack;
        end
        if (!seen) checkOutput(who ? "bAckTimeout" : "cAckTimeout", 32'(seen), 32'h1);
        if (chkLat) checkOutput("ackLatency", 32'(n), we ? 32'd2 : 32'(RL + 3));
        @(posedge clk);
        #1;
        if (drop) begin
            if (who) bIf.req = 1'b0;
            else     cIf.req = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cExp.delete();
        bExp.delete();
        wrQ.delete();
    endtask

    task automatic pulseBootDone();
        bootDone = 1'b1;
        @(posedge clk);
        #1;
        bootDone = 1'b0;
    endtask

    // Monitor: every ack pops a response, every write pulse pops a BRAM write
    always @(negedge clk) begin
        if (!rst) begin
            if (cIf.ack || bIf.ack) checkOutput("ackExclusive", 32'(cIf.ack & bIf.ack), 32'h0);
            if (cIf.ack) begin
                cAckCount++;
                ackLog.push_back(0);
                if (cExp.size() == 0) checkOutput("cUnexpectedAck", 32'h1, 32'h0);
                else begin
                    exp_t e;
                    e = cExp.pop_front();
                    if (!e.we) checkOutput("cRdata", cIf.rdata, e.data);
                end
            end
            if (bIf.ack) begin
                bAckCount++;
                ackLog.push_back(1);
                if (bExp.size() == 0) checkOutput("bUnexpectedAck", 32'h1, 32'h0);
                else begin
                    exp_t e;
                    e = bExp.pop_front();
                    if (!e.we) checkOutput("bRdata", bIf.rdata, e.data);
                end
            end
            if (bramWea) begin
                if (wrQ.size() == 0) checkOutput("unexpectedWrite", 32'h1, 32'h0);
                else begin
                    wr_t w;
                    w = wrQ.pop_front();
                    checkOutput("wrAddr", 32'(bramAddra), w.idx);
                    checkOutput("wrData", bramDina, w.data);
                    checkOutput("wrAckSameCycle", 32'(w.who ? bIf.ack : cIf.ack), 32'h1);
                end
            end
        end
    end

    initial begin
        int savedB;
        rst = 1'b1; bootDone = 1'b0;
        cIf.req = 1'b0; cIf.we = 1'b0; cIf.addr = '0; cIf.wdata = '0;
        bIf.req = 1'b0; bIf.we = 1'b0; bIf.addr = '0; bIf.wdata = '0;
        @(negedge clk);
        checkOutput("rstRun", 32'(run), 32'h0);
        checkOutput("rstWea", 32'(bramWea), 32'h0);
        checkOutput("rstAddra", 32'(bramAddra), 32'h0);
        checkOutput("rstDina", bramDina, 32'h0);
        checkOutput("rstCRdata", cIf.rdata, 32'h0);
        checkOutput("rstBRdata", bIf.rdata, 32'h0);
        checkOutput("rstCAck", 32'(cIf.ack), 32'h0);
        checkOutput("rstBAck", 32'(bIf.ack), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // CPU read is held off until boot_done
        fork
            applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0);
        join_none
        repeat (20) @(negedge clk);
        checkOutput("bootNoAck", 32'(cAckCount), 32'h0);
        checkOutput("bootStall", 32'(cIf.stall), 32'h1);
        checkOutput("bootRun", 32'(run), 32'h0);
        bootDone = 1'b1;
        @(posedge clk);
        #1;
        bootDone = 1'b0;
        @(negedge clk);
        checkOutput("runAfterBoot", 32'(run), 32'h1);
        wait fork;

        applyStimulus(1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, (32'h1 << 20) + 32'h8, 32'h12345678, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 1'b1);

        applyStimulus(1'b0, 1'b1, 32'h100, $urandom, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h104, $urandom, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h104, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h0, $urandom, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h4, $urandom, 1'b1, 1'b0);

        // Fresh reset leaves last grant on the loader, so the CPU wins first
        doReset();
        pulseBootDone();
        ackLog.delete();
        fork
            for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, (i == 3), 1'b0);
            for (int j = 0; j < 4; j++) applyStimulus(1'b1, 1'b0, 32'h4, 32'h0, (j == 3), 1'b0);
        join
        checkOutput("rrCount", 32'(ackLog.size()), 32'd8);
        foreach (ackLog[i]) checkOutput("rrOrder", 32'(ackLog[i]), 32'(i % 2));

        fork
            for (int i = 0; i < 30; i++)
                applyStimulus(1'b0, 1'($urandom_range(0, 1)), randAddr(64), $urandom,
                              1'($urandom_range(0, 1)) | (i == 29), 1'b0);
            for (int j = 0; j < 30; j++)
                applyStimulus(1'b1, 1'($urandom_range(0, 1)), randAddr(96), $urandom,
                              1'($urandom_range(0, 1)) | (j == 29), 1'b0);
        join

        // Reset while the loader read is waiting on BRAM latency
        bIf.req = 1'b1; bIf.we = 1'b0; bIf.addr = 32'h40;
        repeat (2) @(negedge clk);
        savedB = bAckCount;
        doReset();
        bIf.req = 1'b0;
        @(negedge clk);
        checkOutput("midRstWea", 32'(bramWea), 32'h0);
        checkOutput("midRstRun", 32'(run), 32'h0);
        repeat (8) @(negedge clk);
        checkOutput("midRstNoAck", 32'(bAckCount), 32'(savedB));
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b1);

        repeat (4) @(negedge clk);
        checkOutput("cQueueEmpty", 32'(cExp.size()), 32'h0);
        checkOutput("bQueueEmpty", 32'(bExp.size()), 32'h0);
        checkOutput("wrQueueEmpty", 32'(wrQ.size()), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
